// File: rtl/osiris_i_pkg.sv
// Shared constants for the Osiris I execute stage: M-extension funct3, MD FSM states, forwarding selects, ALU ops.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package osiris_i_pkg;

    // M-extension funct3 encodings
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Iterative multiply/divide sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Forwarding mux selects (11 falls back to the register file)
    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_REG2 = 2'b11;

    // ALU operation encodings
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    // Divide-class ops have funct3[2] set
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU with equality flag for branch compare.
// Latency: combinational.
// Backpressure: none.
module alu import osiris_i_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_ctrl,
    output logic [WIDTH-1:0] o_result,
    output logic             o_equal
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = i_b[SHW-1:0];
    assign o_equal = (i_a == i_b);

    // Operation decode
    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_SLT:   o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU:  o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on latched operand magnitudes.
// Latency: start cycle + DATA_WIDTH busy cycles + one done cycle carrying the result.
// Backpressure: none; the caller holds the pipeline while busy, flush aborts at any state.
module md_unit import osiris_i_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

    md_state_t            r_state, w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_op;
    logic [W-1:0]         r_opnd;     // multiplicand or divisor magnitude
    logic [2*W-1:0]       r_acc;      // {hi, lo}: product, or {remainder, quotient}
    logic                 r_neg_res;  // product / quotient sign
    logic                 r_neg_rem;  // remainder sign (dividend's)

    logic           w_div, w_a_neg, w_b_neg;
    logic [W-1:0]   w_mag_a, w_mag_b;
    logic [W:0]     w_sum, w_top, w_diff;
    logic           w_ge;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo, w_rem;

    // Operand signedness and magnitudes at start
    always_comb begin
        w_div   = md_is_div(i_op);
        w_a_neg = i_op_a[W-1] & ((i_op == MD_MULH) || (i_op == MD_MULHSU) ||
                                 (i_op == MD_DIV)  || (i_op == MD_REM));
        w_b_neg = i_op_b[W-1] & ((i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM));
        w_mag_a = w_a_neg ? -i_op_a : i_op_a;
        w_mag_b = w_b_neg ? -i_op_b : i_op_b;
    end

    // One radix-2 step for both datapaths; borrow out of the trial subtract decides the quotient bit
    always_comb begin
        w_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_top  = r_acc[2*W-1:W-1];
        w_diff = w_top - {1'b0, r_opnd};
        w_ge   = ~w_diff[W];
    end

    // Sign fixup and result-half selection; divide-by-zero and MIN/-1 fall out of the magnitude datapath
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_quo    = r_neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_rem    = r_neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
        o_result = w_prod[W-1:0];
        case (r_op)
            MD_MUL:                       o_result = w_prod[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[2*W-1:W];
            MD_DIV, MD_DIVU:              o_result = w_quo;
            default:                      o_result = w_rem;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    // Next state: flush always returns to idle; a start held through DONE does not retrigger
    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (i_start) w_next = MD_BUSY;
                MD_BUSY: if (r_cnt == LAST) w_next = MD_DONE;
                default: w_next = MD_IDLE;
            endcase
        end
    end

    // Operand latch on accept, then one shift step per busy cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (r_state == MD_IDLE && i_start && !i_flush) begin
            r_cnt     <= '0;
            r_op      <= i_op;
            r_opnd    <= w_div ? w_mag_b : w_mag_a;
            r_acc     <= {{W{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
            r_neg_res <= w_div ? ((w_a_neg ^ w_b_neg) && (i_op_b != '0)) : (w_a_neg ^ w_b_neg);
            r_neg_rem <= w_a_neg;
        end else if (r_state == MD_BUSY) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (md_is_div(r_op)) r_acc <= {(w_ge ? w_diff[W-1:0] : w_top[W-1:0]), r_acc[W-2:0], w_ge};
            else                 r_acc <= {w_sum, r_acc[W-1:1]};
        end
    end

    assign o_busy = (r_state == MD_BUSY);
    assign o_done = (r_state == MD_DONE) && !i_flush;
endmodule

// File: rtl/mux_2x1.sv
// Two-input word multiplexer.
// Latency: combinational.
// Backpressure: none.
module mux_2x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/mux_4x1.sv
// Four-input word multiplexer.
// Latency: combinational.
// Backpressure: none.
module mux_4x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);
    // Select one of four words
    always_comb begin
        o_y = i_a;
        case (i_sel)
            2'b01:   o_y = i_b;
            2'b10:   o_y = i_c;
            2'b11:   o_y = i_d;
            default: o_y = i_a;
        endcase
    end
endmodule

// File: rtl/pc_target.sv
// Branch/jump target adder: PC plus extended immediate.
// Latency: combinational.
// Backpressure: none.
module pc_target #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_target
);
    assign o_target = i_pc + i_imm;
endmodule

// File: rtl/stage_execute_md.sv
// Execute stage: forwarding, single-cycle ALU/compare/PC-target, plus iterative RV32M unit.
// Latency: ALU paths combinational; M ops take DATA_WIDTH+2 cycles with the result in the last.
// Backpressure: o_stall_EX holds IF/ID/EX while an M op is accepted or iterating; flush drops it.
module stage_execute_md import osiris_i_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rd1_EX,
    input  logic [DATA_WIDTH-1:0] i_rd2_EX,
    input  logic [DATA_WIDTH-1:0] i_pc_EX,
    input  logic [DATA_WIDTH-1:0] i_imm_ext_EX,
    input  logic [DATA_WIDTH-1:0] i_result_WB,
    input  logic [DATA_WIDTH-1:0] i_alu_result_M,
    input  logic [1:0]            i_forward_rs1_EX,
    input  logic [1:0]            i_forward_rs2_EX,
    input  logic                  i_alu_src_EX,
    input  logic [4:0]            i_alu_ctrl_EX,
    input  logic                  i_md_start_EX,
    input  logic [2:0]            i_md_op_EX,
    input  logic                  i_flush_EX,
    output logic                  o_equal_EX,
    output logic [DATA_WIDTH-1:0] o_alu_result_EX,
    output logic [DATA_WIDTH-1:0] o_write_data_EX,
    output logic [DATA_WIDTH-1:0] o_pc_target_EX,
    output logic                  o_stall_EX
);
    logic [DATA_WIDTH-1:0] w_src_a, w_src_b, w_alu_out, w_md_result;
    logic                  w_md_busy, w_md_done;

    mux_4x1 #(.WIDTH(DATA_WIDTH)) u_fwd_a (
        .i_a(i_rd1_EX), .i_b(i_result_WB), .i_c(i_alu_result_M), .i_d(i_rd1_EX),
        .i_sel(i_forward_rs1_EX), .o_y(w_src_a)
    );

    mux_4x1 #(.WIDTH(DATA_WIDTH)) u_fwd_b (
        .i_a(i_rd2_EX), .i_b(i_result_WB), .i_c(i_alu_result_M), .i_d(i_rd2_EX),
        .i_sel(i_forward_rs2_EX), .o_y(o_write_data_EX)
    );

    mux_2x1 #(.WIDTH(DATA_WIDTH)) u_src_b (
        .i_a(o_write_data_EX), .i_b(i_imm_ext_EX), .i_sel(i_alu_src_EX), .o_y(w_src_b)
    );

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .i_a(w_src_a), .i_b(w_src_b), .i_ctrl(i_alu_ctrl_EX),
        .o_result(w_alu_out), .o_equal(o_equal_EX)
    );

    pc_target #(.WIDTH(DATA_WIDTH)) u_pc_target (
        .i_pc(i_pc_EX), .i_imm(i_imm_ext_EX), .o_target(o_pc_target_EX)
    );

    // M ops always take the forwarded rs2, never the immediate
    md_unit #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_md (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_md_start_EX), .i_op(i_md_op_EX),
        .i_op_a(w_src_a), .i_op_b(o_write_data_EX), .i_flush(i_flush_EX),
        .o_result(w_md_result), .o_busy(w_md_busy), .o_done(w_md_done)
    );

    mux_2x1 #(.WIDTH(DATA_WIDTH)) u_res (
        .i_a(w_alu_out), .i_b(w_md_result), .i_sel(w_md_done), .o_y(o_alu_result_EX)
    );

    // Idle is neither busy nor done; DONE itself releases the pipeline
    assign o_stall_EX = !i_flush_EX &&
                        ((!w_md_busy && !w_md_done && i_md_start_EX) || w_md_busy);
endmodule

// File: tb/tb_stage_execute_md.sv
module tb_stage_execute_md;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd1, rd2, pc, imm, res_wb, res_m;
    logic [1:0]  fwd1, fwd2;
    logic        alu_src, md_start, flush;
    logic [4:0]  alu_ctrl;
    logic [2:0]  md_op;
    logic        equal, stall;
    logic [31:0] alu_result, write_data, pc_target_o;

    int checks = 0;
    int errors = 0;

    stage_execute_md #(.DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rd1_EX(rd1), .i_rd2_EX(rd2), .i_pc_EX(pc), .i_imm_ext_EX(imm),
        .i_result_WB(res_wb), .i_alu_result_M(res_m),
        .i_forward_rs1_EX(fwd1), .i_forward_rs2_EX(fwd2),
        .i_alu_src_EX(alu_src), .i_alu_ctrl_EX(alu_ctrl),
        .i_md_start_EX(md_start), .i_md_op_EX(md_op), .i_flush_EX(flush),
        .o_equal_EX(equal), .o_alu_result_EX(alu_result), .o_write_data_EX(write_data),
        .o_pc_target_EX(pc_target_o), .o_stall_EX(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: issue an M op, hold start until the result cycle, check latency and value
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        md_start = 1'b1; md_op = op; rd1 = a; rd2 = b;
        fwd1 = 2'b00; fwd2 = 2'b00; alu_src = 1'b1; imm = 32'h55;
        cyc = 1;
        @(negedge clk);
        chk({tag, " stall_at_start"}, {31'b0, stall}, 32'd1);
        while (stall && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            @(negedge clk);
        end
        chk({tag, " cycles"}, cyc, 32'd34);
        chk({tag, " result"}, alu_result, exp);
        @(posedge clk); #1;
        md_start = 1'b0; alu_src = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; rd1 = 32'd3; rd2 = 32'd4; pc = 32'h1000; imm = 32'h20;
        res_wb = 32'h100; res_m = 32'h50; fwd1 = 2'b00; fwd2 = 2'b00;
        alu_src = 1'b0; alu_ctrl = 5'b00000; md_start = 1'b0; md_op = 3'b000; flush = 1'b0;
        #2;
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset add", alu_result, 32'd7);
        chk("pc_target", pc_target_o, 32'h1020);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Forwarding and ALU paths
        fwd1 = 2'b01; fwd2 = 2'b10;
        @(negedge clk);
        chk("fwd wb+m add", alu_result, 32'h150);
        chk("fwd m write_data", write_data, 32'h50);
        fwd1 = 2'b11; fwd2 = 2'b11;
        @(negedge clk);
        chk("fwd 11 regfile", write_data, 32'd4);
        fwd1 = 2'b00; fwd2 = 2'b00; rd1 = 32'd9; rd2 = 32'd9; alu_ctrl = 5'b00001;
        @(negedge clk);
        chk("sub zero", alu_result, 32'd0);
        chk("equal flag", {31'b0, equal}, 32'd1);
        rd1 = 32'd3; alu_ctrl = 5'b00000; alu_src = 1'b1;
        @(negedge clk);
        chk("add imm", alu_result, 32'h23);
        chk("not equal", {31'b0, equal}, 32'd0);
        @(posedge clk); #1; alu_src = 1'b0;

        // Multiply / divide vectors
        run_md("MUL", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run_md("MULH", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run_md("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        run_md("DIV", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_md("REM", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_md("DIVU0", 3'b101, 32'h1234, 32'd0, 32'hFFFFFFFF);
        run_md("REMU0", 3'b111, 32'h1234, 32'd0, 32'h1234);
        run_md("DIV0s", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
        run_md("REM0s", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
        run_md("DIVovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_md("REMovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        // Operand latch: rs1 forwarded from M, forwarding inputs disturbed in cycle 5
        md_start = 1'b1; md_op = 3'b100; rd1 = 32'd0; rd2 = 32'd7;
        res_m = 32'd100; fwd1 = 2'b10; fwd2 = 2'b00;
        cyc = 1;
        @(negedge clk);
        while (stall && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 5) begin
                res_m = 32'd999; res_wb = 32'd1; fwd1 = 2'b00; fwd2 = 2'b01; rd1 = 32'd3;
            end
            @(negedge clk);
        end
        chk("latch cycles", cyc, 32'd34);
        chk("latch result", alu_result, 32'd14);
        @(posedge clk); #1;
        md_start = 1'b0; fwd1 = 2'b00; fwd2 = 2'b00;

        // Flush in cycle 10 of a DIV
        md_start = 1'b1; md_op = 3'b100; rd1 = 32'd100; rd2 = 32'd7;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; md_start = 1'b0; alu_ctrl = 5'b00000; alu_src = 1'b1;
        rd1 = 32'd5; imm = 32'd10;
        @(negedge clk);
        chk("post-flush add", alu_result, 32'd15);
        chk("post-flush stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1; alu_src = 1'b0;
        run_md("MUL after flush", 3'b000, 32'd6, 32'd7, 32'd42);

        // Asynchronous reset in BUSY cycle 12
        md_start = 1'b1; md_op = 3'b000; rd1 = 32'd11; rd2 = 32'd13;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; md_start = 1'b0; alu_src = 1'b0; alu_ctrl = 5'b00000;
        #1;
        chk("reset mid-op stall", {31'b0, stall}, 32'd0);
        chk("reset mid-op alu", alu_result, 32'd24);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_md("MUL after reset", 3'b000, 32'd11, 32'd13, 32'd143);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_execute_md.md
# stage_execute_md

Next-generation execute stage for the Osiris I pipeline. Keeps single-cycle ALU, branch-compare and PC-target paths with EX forwarding, and adds an iterative RV32M multiply/divide unit. The unit latches its operands, stalls the pipeline while it iterates, and drives the result onto the EX ALU-result bus for one cycle. It sits between the ID/EX and EX/M pipeline registers and reports stall to the hazard unit.

## Interface
- DATA_WIDTH, 32: datapath width; must be even and ≥ 8.
- CNT_WIDTH, $clog2(DATA_WIDTH+1): width of the iteration counter.
- i_clk  in  1  pipeline clock; all state updates on rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_rd1_EX, i_rd2_EX  in  DATA_WIDTH  register-file operands.
- i_pc_EX, i_imm_ext_EX  in  DATA_WIDTH  PC and extended immediate.
- i_result_WB, i_alu_result_M  in  DATA_WIDTH  forwarding sources.
- i_forward_rs1_EX, i_forward_rs2_EX  in  2  forwarding selects: 00 = regfile, 01 = WB, 10 = M, 11 = regfile.
- i_alu_src_EX  in  1  srcB select: 0 = forwarded rs2, 1 = immediate.
- i_alu_ctrl_EX  in  5  ALU op; encoding unchanged from the existing alu.
- i_md_start_EX  in  1  the instruction in EX is an M-extension op.
- i_md_op_EX  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_flush_EX  in  1  squash the instruction in EX.
- o_equal_EX  out  1  ALU compare flag.
- o_alu_result_EX  out  DATA_WIDTH  ALU result, or the MD result during DONE.
- o_write_data_EX  out  DATA_WIDTH  forwarded rs2.
- o_pc_target_EX  out  DATA_WIDTH  i_pc_EX + i_imm_ext_EX.
- o_stall_EX  out  1  hold IF/ID/EX and bubble M.

## Operation
- Non-M path:
  - Combinational and identical to the current execute stage.
  - When i_md_start_EX = 0, o_alu_result_EX is the ALU output.
- MD state machine (IDLE, BUSY, DONE):
  - IDLE, with start = 1 and flush = 0:
    - Latch forwarded srcA and forwarded rs2; i_alu_src_EX is ignored for M ops.
    - Latch the op, compute operand magnitudes and the result sign.
    - Clear the counter and go to BUSY.
  - BUSY: one radix-2 step per cycle. MUL uses shift-add into a 2·DATA_WIDTH accumulator. DIV uses restoring shift-subtract. After DATA_WIDTH steps, go to DONE.
  - DONE:
    - Apply the sign fixup and select the result half: MUL = low word, MULH* = high word, DIV* = quotient, REM* = remainder.
    - Drive o_alu_result_EX for this cycle, then go to IDLE.
    - A start still asserted in DONE is the same instruction and never retriggers.
- Special cases, resolved in DONE:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN; remainder = 0.
- Signedness of rs1/rs2: MULH = s/s, MULHSU = s/u, MULHU = u/u, DIV/REM = s/s, DIVU/REMU = u/u.
- Result sign: remainder takes the dividend's sign; quotient is negative iff operand signs differ and the divisor is non-zero.
- o_stall_EX = !i_flush_EX && ((IDLE && i_md_start_EX) || BUSY).
- Flush: any state with i_flush_EX = 1 goes to IDLE next edge; no result is produced.
- Reset (asynchronous, any state, mid-operation included):
  - State goes to IDLE; counter, operand and accumulator registers clear to 0.
  - o_stall_EX = 0 once i_md_start_EX = 0.

## Timing
- ALU, compare and PC-target outputs: zero latency.
- An M op occupies EX for DATA_WIDTH+2 cycles: start cycle, DATA_WIDTH BUSY cycles, one DONE cycle. That is 34 cycles at DATA_WIDTH = 32.
- o_stall_EX is high for the first DATA_WIDTH+1 of those cycles and low in DONE, so EX/M captures the result at the end of DONE.
- Latched operands make the result immune to forwarding-input changes after the start cycle.
- Back-to-back M ops: a new start is accepted in the IDLE cycle that follows DONE.

## Structure
- Package osiris_i_pkg:
  - MD funct3 localparams.
  - State encodings MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2.
  - Forwarding-select constants.
- Sub-module md_unit:
  - Contains the FSM, counter, shift-add/shift-subtract datapath and fixup.
  - Ports: clock, reset, start, op, two operands, flush, result, busy, done.
- The top level reuses alu, pc_target, mux_4x1 and mux_2x1, plus a 2:1 result mux selected by done.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD: stall for 33 cycles, result 0xFFFFFFEB in cycle 34.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV and REM, −7 / 2: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- DIVU and REMU, 0x1234 / 0:
  - DIVU → 0xFFFFFFFF; REMU → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Start a DIV, then change i_alu_result_M and the forward selects in cycle 5: result unchanged.
- Start a DIV, then flush in cycle 10:
  - Stall drops in that cycle; state is IDLE next cycle.
  - An ADD issued next is single-cycle and correct.
- Assert i_rst in BUSY cycle 12:
  - Immediately IDLE with stall 0.
  - A fresh MUL after reset completes in 34 cycles.
